ac97_sample_feeder: RTL and testbench
=====================================

# ac97_sample_feeder

Upstream stage of the AC97 output frame builder. Buffers stereo 16-bit PCM sample pairs from the audio source in a small FIFO and presents one 20-bit left/right pair to the frame builder per 256-bit AC97 frame. It handles start-up priming, underrun detection and mono duplication, all in the `bitclk` domain.

## Interface

Parameters:
- `DEPTH`, 16: FIFO depth in stereo pairs; must be a power of two, at least 4.
- `ADDR_W`, 4: log2(`DEPTH`).
- `PRIME_LEVEL`, 8: fill level required before playback starts or resumes; range 1..`DEPTH`.

Ports:
- `bitclk`, in, 1: AC97 bit clock (12.288 MHz); the only clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `play`, in, 1: playback enable, level-sensitive.
- `mono`, in, 1: when 1, the right output copies the left sample.
- `s_data`, in, 32: sample pair {left[31:16], right[15:0]}, two's complement.
- `s_valid`, in, 1: `s_data` is valid.
- `s_ready`, out, 1: FIFO can accept a pair.
- `frame_req`, in, 1: one-cycle pulse from the frame builder at the last bit (bit 255) of each frame.
- `pcm_left`, out, 20: left slot data (slot 3).
- `pcm_right`, out, 20: right slot data (slot 4).
- `pcm_valid`, out, 1: slot 3/4 tag valid bits for the next frame.
- `underrun`, out, 1: one-cycle pulse on each underrun.
- `underrun_count`, out, 16: saturating underrun counter.
- `fill_level`, out, `ADDR_W`+1: current FIFO occupancy, 0..`DEPTH`.

## Operation

- FIFO:
  - Push when `s_valid && s_ready`.
  - `s_ready` = (`fill_level` != `DEPTH`) && `play`.
  - Read and write pointers are `ADDR_W` bits wide and wrap modulo `DEPTH`.
- Width conversion: 20-bit value = {sample16, 4'b0000}. No rounding; sign is preserved.
- State machine (states IDLE, PRIME, RUN):
  - IDLE: outputs zero, `pcm_valid`=0. FIFO is flushed (pointers and count cleared). Goes to PRIME when `play`=1.
  - PRIME: pushes are accepted. On `frame_req`, outputs zero with `pcm_valid`=0; no pop, no underrun. Goes to RUN when `fill_level` >= `PRIME_LEVEL`; the check is made every cycle, not only on `frame_req`.
  - RUN, on `frame_req` with `fill_level` > 0: pop one pair, load `pcm_left`/`pcm_right` (right = left if `mono`), set `pcm_valid`=1.
  - RUN, on `frame_req` with `fill_level` == 0: underrun. Outputs go to zero, `pcm_valid`=0, `underrun` pulses, `underrun_count` increments (holds at 16'hFFFF), state goes to PRIME.
  - Any state, `play`=0: go to IDLE on the next edge. `play` has priority over every other event.
- `mono` is sampled at pop time only; changing it mid-frame has no effect on the held outputs.
- `underrun_count` clears only on `reset`. IDLE does not clear it.

## Timing

- Reset values:
  - State = IDLE.
  - `pcm_left`, `pcm_right` = 0; `pcm_valid` = 0; `underrun` = 0.
  - `underrun_count` = 0; `fill_level` = 0; `s_ready` = 0.
  - Pointers = 0.
- Pop latency: `frame_req` high at edge t gives new `pcm_*` registered at t+1. Outputs then hold stable until the next `frame_req`, which is 256 cycles later in normal operation and well before the builder samples slot 3.
- `fill_level` and `s_ready` are registered and reflect the push/pop of the previous edge.
- Push and pop in the same cycle: both occur and the count is unchanged.
- Pop at `fill_level`=0 coincident with a push: counted as an underrun. The pushed pair is stored and is not output this frame.
- Push while full: cannot occur, because `s_ready`=0.
- `frame_req` in the same cycle as `play` falling: IDLE wins. No pop, no underrun, outputs zero at t+1.
- `reset` asserted mid-frame: all outputs go to their reset values immediately (asynchronous). Release is synchronous to `bitclk`.
- Back-to-back `frame_req` pulses (protocol violation): each pulse pops independently. No error is flagged.

## Test plan

- Reset and prime: `reset` low, then high with `play`=1, push 8 pairs {16'h1234,16'h8000} with no `frame_req` -> state RUN after the 8th push, `fill_level`=8. First `frame_req` -> `pcm_left`=20'h12340, `pcm_right`=20'h80000, `pcm_valid`=1 one cycle later, `fill_level`=7.
- Priming hold: push 5 pairs, pulse `frame_req` 3 times -> `pcm_valid`=0, outputs 0, `fill_level` stays 5, `underrun_count`=0.
- Underrun: prime with 8 pairs, issue 9 `frame_req` pulses with no further pushes -> 8 valid outputs in order. 9th: outputs 0, `pcm_valid`=0, `underrun` one pulse, `underrun_count`=1, state PRIME.
- Full and wrap: push 20 pairs with no pops -> `s_ready` drops after the 16th, `fill_level`=16. Then 16 pops with interleaved pushes -> output order matches input order across pointer wrap, with no loss or duplication.
- Mono and simultaneous push/pop: at `fill_level`=4 in RUN, with `mono`=1, push {16'hFFFF,16'h0001} in the same cycle as `frame_req` -> `fill_level` stays 4, `pcm_right` == `pcm_left`.
- Stop and async reset: `play`=0 coincident with `frame_req` -> IDLE, `fill_level`=0, outputs 0, `underrun_count` unchanged. Assert `reset` mid-frame -> all outputs at reset values before the next `bitclk` edge.

Source files
------------

// File: rtl/ac97_sample_feeder.sv
// AC97 sample feeder: buffers stereo PCM pairs and presents
// one 20-bit left/right pair per AC97 frame.
module ac97_sample_feeder #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int PRIME_LEVEL = 8
) (
  input  logic              bitclk,
  input  logic              reset,
  input  logic              play,
  input  logic              mono,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              frame_req,
  output logic [19:0]       pcm_left,
  output logic [19:0]       pcm_right,
  output logic              pcm_valid,
  output logic              underrun,
  output logic [15:0]       underrun_count,
  output logic [ADDR_W:0]   fill_level
);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL  = (ADDR_W+1)'(PRIME_LEVEL);

  state_t state, state_nxt;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_data;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              push, pop, flush, urun, clear;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge bitclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    pop       = 1'b0;
    urun      = 1'b0;
    flush     = 1'b0;
    clear     = 1'b0;
    state_nxt = state;
    push      = s_valid && s_ready;

    if (!play) begin
      flush = 1'b1;
      clear = 1'b1;
    end else if (state == RUN && frame_req) begin
      if (fill_level != '0) begin
        pop = 1'b1;
      end else begin
        urun  = 1'b1;
        clear = 1'b1;
      end
    end else if (state == PRIME && frame_req) begin
      clear = 1'b1;
    end
    if (state == IDLE) begin
      flush = 1'b1;
      clear = 1'b1;
    end

    count_nxt = flush ? '0
              : fill_level + (ADDR_W+1)'(push)
                           - (ADDR_W+1)'(pop);

    // play low overrides every other event
    if (!play) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = PRIME;
        PRIME:   if (count_nxt >= LVL) state_nxt = RUN;
        RUN:     if (urun) state_nxt = PRIME;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge bitclk) begin
    if (push && !flush) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge bitclk or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_level     <= '0;
      s_ready        <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
      pcm_left       <= '0;
      pcm_right      <= '0;
      pcm_valid      <= 1'b0;
    end else begin
      fill_level <= count_nxt;
      s_ready    <= play && (count_nxt != FULL);
      underrun   <= urun;

      if (flush)     wr_ptr <= '0;
      else if (push) wr_ptr <= wr_ptr + 1'b1;

      if (flush)     rd_ptr <= '0;
      else if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (urun && underrun_count != 16'hFFFF)
        underrun_count <= underrun_count + 16'd1;

      if (pop) begin
        pcm_left  <= {rd_data[31:16], 4'b0000};
        pcm_right <= mono ? {rd_data[31:16], 4'b0000}
                          : {rd_data[15:0], 4'b0000};
        pcm_valid <= 1'b1;
      end else if (clear) begin
        pcm_left  <= '0;
        pcm_right <= '0;
        pcm_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ac97_sample_feeder.sv
// Directed bench for ac97_sample_feeder: priming, underrun,
// full/wrap, mono, stop and async reset.
module tb_ac97_sample_feeder;

  logic        bitclk = 1'b0;
  logic        reset;
  logic        play;
  logic        mono;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        frame_req;
  logic [19:0] pcm_left;
  logic [19:0] pcm_right;
  logic        pcm_valid;
  logic        underrun;
  logic [15:0] underrun_count;
  logic [4:0]  fill_level;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] q[$];
  logic [31:0] e;

  ac97_sample_feeder #(
    .DEPTH(16), .ADDR_W(4), .PRIME_LEVEL(8)
  ) dut (
    .bitclk(bitclk),
    .reset(reset),
    .play(play),
    .mono(mono),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .frame_req(frame_req),
    .pcm_left(pcm_left),
    .pcm_right(pcm_right),
    .pcm_valid(pcm_valid),
    .underrun(underrun),
    .underrun_count(underrun_count),
    .fill_level(fill_level)
  );

  always #5 bitclk = ~bitclk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge bitclk);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] d);
    int n;
    n = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (!s_ready) check("push_timeout", 32'd0, 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    play      = 1'b0;
    mono      = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    frame_req = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    play  = 1'b1;
    tick();
  endtask

  task automatic check_pair(input string tag,
                            input logic [31:0] d);
    check({tag, "_l"}, 32'(pcm_left),  {12'h0, d[31:16], 4'h0});
    check({tag, "_r"}, 32'(pcm_right), {12'h0, d[15:0], 4'h0});
    check({tag, "_v"}, 32'(pcm_valid), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset values, with play already high during reset
    reset = 1'b0; play = 1'b1; mono = 1'b0;
    s_valid = 1'b0; s_data = '0; frame_req = 1'b0;
    #12;
    check("rst_left",   32'(pcm_left), 0);
    check("rst_right",  32'(pcm_right), 0);
    check("rst_valid",  32'(pcm_valid), 0);
    check("rst_urun",   32'(underrun), 0);
    check("rst_ucount", 32'(underrun_count), 0);
    check("rst_fill",   32'(fill_level), 0);
    check("rst_ready",  32'(s_ready), 0);

    // reset and prime
    do_reset();
    check("t1_ready", 32'(s_ready), 1);
    for (int i = 0; i < 8; i++) push_pair(32'h1234_8000);
    check("t1_fill8", 32'(fill_level), 8);
    check("t1_nvalid", 32'(pcm_valid), 0);
    pulse_frame();
    check("t1_left",  32'(pcm_left),  32'h12340);
    check("t1_right", 32'(pcm_right), 32'h80000);
    check("t1_valid", 32'(pcm_valid), 1);
    check("t1_fill7", 32'(fill_level), 7);

    // priming hold
    do_reset();
    for (int i = 0; i < 5; i++) push_pair(32'hAAAA_5555);
    for (int i = 0; i < 3; i++) begin
      pulse_frame();
      check("t2_valid",  32'(pcm_valid), 0);
      check("t2_left",   32'(pcm_left), 0);
      check("t2_fill",   32'(fill_level), 5);
      check("t2_ucount", 32'(underrun_count), 0);
      check("t2_urun",   32'(underrun), 0);
      tick();
    end

    // full and wrap
    do_reset();
    q.delete();
    begin
      int k;
      k = 0;
      s_valid = 1'b1;
      for (int c = 0; c < 24; c++) begin
        s_data = {16'(16'h3000 + k), 16'(16'h4000 + k)};
        if (s_ready) begin
          q.push_back(s_data);
          k++;
        end
        tick();
      end
      s_valid = 1'b0;
      check("t4_pushed", 32'(k), 16);
    end
    check("t4_fill16", 32'(fill_level), 16);
    check("t4_ready0", 32'(s_ready), 0);
    for (int i = 0; i < 24; i++) begin
      pulse_frame();
      e = q.pop_front();
      check_pair("t4_pop", e);
      if (i < 8) begin
        e = {16'(16'h5000 + i), 16'(16'h6000 + i)};
        q.push_back(e);
        push_pair(e);
      end else begin
        tick();
      end
    end
    check("t4_fill0", 32'(fill_level), 0);

    // mono with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++)
      push_pair({16'(16'h0A00 + i), 16'(16'h0B00 + i)});
    for (int i = 0; i < 4; i++) begin
      pulse_frame();
      tick();
    end
    check("t5_fill4", 32'(fill_level), 4);
    mono      = 1'b1;
    s_data    = 32'hFFFF_0001;
    s_valid   = 1'b1;
    frame_req = 1'b1;
    tick();
    s_valid   = 1'b0;
    frame_req = 1'b0;
    check("t5_fill", 32'(fill_level), 4);
    check("t5_left", 32'(pcm_left), 32'h0A040);
    check("t5_mono", 32'(pcm_right), 32'h0A040);
    mono = 1'b0;
    tick();
    check("t5_hold", 32'(pcm_right), 32'h0A040);
    for (int i = 5; i < 8; i++) begin
      pulse_frame();
      check_pair("t5_pop", {16'(16'h0A00 + i), 16'(16'h0B00 + i)});
    end
    pulse_frame();
    check_pair("t5_pushed", 32'hFFFF_0001);

    // underrun
    do_reset();
    for (int i = 0; i < 8; i++)
      push_pair({16'(16'h1000 + i), 16'(16'h2000 + i)});
    for (int i = 0; i < 8; i++) begin
      pulse_frame();
      check_pair("t3_pop", {16'(16'h1000 + i), 16'(16'h2000 + i)});
      tick();
    end
    pulse_frame();
    check("t3_urun",   32'(underrun), 1);
    check("t3_left",   32'(pcm_left), 0);
    check("t3_right",  32'(pcm_right), 0);
    check("t3_valid",  32'(pcm_valid), 0);
    check("t3_ucount", 32'(underrun_count), 1);
    tick();
    check("t3_pulse",  32'(underrun), 0);
    pulse_frame();
    check("t3_prime_urun", 32'(underrun), 0);
    check("t3_prime_cnt",  32'(underrun_count), 1);

    // stop coincident with frame_req
    for (int i = 0; i < 8; i++)
      push_pair({16'(16'h7000 + i), 16'(16'h7800 + i)});
    pulse_frame();
    check_pair("t6_run", 32'h7000_7800);
    play      = 1'b0;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    check("t6_fill",   32'(fill_level), 0);
    check("t6_valid",  32'(pcm_valid), 0);
    check("t6_left",   32'(pcm_left), 0);
    check("t6_urun",   32'(underrun), 0);
    check("t6_ucount", 32'(underrun_count), 1);
    check("t6_ready",  32'(s_ready), 0);

    // async reset mid-frame
    play = 1'b1;
    tick();
    for (int i = 0; i < 8; i++)
      push_pair({16'(16'h7100 + i), 16'(16'h7900 + i)});
    pulse_frame();
    check_pair("t6_run2", 32'h7100_7900);
    @(posedge bitclk);
    #3;
    reset = 1'b0;
    #1;
    check("ar_left",   32'(pcm_left), 0);
    check("ar_right",  32'(pcm_right), 0);
    check("ar_valid",  32'(pcm_valid), 0);
    check("ar_urun",   32'(underrun), 0);
    check("ar_ucount", 32'(underrun_count), 0);
    check("ar_fill",   32'(fill_level), 0);
    check("ar_ready",  32'(s_ready), 0);
    tick();
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
